// File: rtl/cassette_fsk_encoder.sv
// FSK cassette-tape bit encoder: buffers host words in a small FIFO and
// serialises each bit as square-wave tone bursts timed by a phase accumulator.
module cassette_fsk_encoder #(
    parameter int ACC_W      = 24,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HALF1      = 1,
    parameter int CYC1       = 1,
    parameter int HALF0      = 2,
    parameter int CYC0       = 1,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ACC_W-1:0]              step,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          dout,
    output logic                          busy,
    output logic                          word_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0]       H1_LAST  = 4'(HALF1 - 1);
    localparam logic [3:0]       C1_LAST  = 4'(CYC1 - 1);
    localparam logic [3:0]       H0_LAST  = 4'(HALF0 - 1);
    localparam logic [3:0]       C0_LAST  = 4'(CYC0 - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_BIT} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count, count_nxt;
    logic              push, pop, load, done;
    logic              fifo_ne;
    logic [DATA_W-1:0] head;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    sum;
    logic              tick;
    logic [DATA_W-1:0] shreg, shifted;
    logic [3:0]        hcnt, ccnt;
    logic [3:0]        h_last, c_last;
    logic              phase;
    logic [IDX_W-1:0]  idx;
    logic              cur, half_end, low_end, bit_end, last_bit;

    assign push    = in_valid & in_ready;
    assign fifo_ne = (count != '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + LVL_W'(1);
            2'b01:   count_nxt = count - LVL_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            in_ready <= (count_nxt != LVL_FULL);
        end
    end

    // Tone timing: a tick is the accumulator carry-out for this clk.
    assign sum      = {1'b0, acc} + {1'b0, step};
    assign tick     = sum[ACC_W];
    assign cur      = LSB_FIRST ? shreg[0] : shreg[DATA_W-1];
    assign shifted  = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    assign h_last   = cur ? H1_LAST : H0_LAST;
    assign c_last   = cur ? C1_LAST : C0_LAST;
    assign half_end = tick & (hcnt == h_last);
    assign low_end  = half_end & phase;
    assign bit_end  = low_end & (ccnt == c_last);
    assign last_bit = (idx == IDX_LAST);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && fifo_ne) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = S_BIT;
                end
            end
            S_BIT: begin
                if (bit_end && last_bit) begin
                    done = 1'b1;
                    if (enable && fifo_ne) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // A chained word keeps the accumulator running so the tone phase is continuous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            shreg     <= '0;
            hcnt      <= '0;
            ccnt      <= '0;
            phase     <= 1'b0;
            idx       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= done;
            if (state == S_IDLE) begin
                if (load) begin
                    acc   <= '0;
                    hcnt  <= '0;
                    ccnt  <= '0;
                    phase <= 1'b0;
                    idx   <= '0;
                    shreg <= head;
                end
            end else begin
                acc <= sum[ACC_W-1:0];
                if (tick)
                    hcnt <= half_end ? 4'd0 : hcnt + 4'd1;
                if (half_end)
                    phase <= ~phase;
                if (low_end)
                    ccnt <= bit_end ? 4'd0 : ccnt + 4'd1;
                if (bit_end) begin
                    idx   <= last_bit ? '0 : idx + IDX_W'(1);
                    shreg <= load ? head : shifted;
                end
            end
        end
    end

    assign busy       = (state == S_BIT);
    assign dout       = busy ? ~phase : IDLE_LEVEL;
    assign fifo_level = count;

endmodule

// File: tb/tb_cassette_fsk_encoder.sv
// Self-checking bench for cassette_fsk_encoder: directed scenarios plus random
// word streams compared cycle by cycle against a tick-level waveform model.
`timescale 1ns/1ps
module tb_cassette_fsk_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] step;
    logic        enable;
    logic [7:0]  in_data;
    logic        in_valid, in_valid_b;
    logic        in_ready, dout, busy, word_done;
    logic        in_ready_b, dout_b, busy_b, word_done_b;
    logic [2:0]  fifo_level, fifo_level_b;

    int n_checks = 0;
    int n_fail   = 0;

    bit         lv_q[$];
    int         bnd_q[$];
    logic [7:0] wq[$];

    always #5 clk = ~clk;

    cassette_fsk_encoder dut (
        .clk(clk), .reset_n(reset_n), .step(step), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .busy(busy), .word_done(word_done), .fifo_level(fifo_level)
    );

    cassette_fsk_encoder #(.LSB_FIRST(1'b0), .HALF1(2), .CYC1(2)) dut_msb (
        .clk(clk), .reset_n(reset_n), .step(step), .enable(enable),
        .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .dout(dout_b), .busy(busy_b), .word_done(word_done_b), .fifo_level(fifo_level_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit to_b);
        @(negedge clk);
        in_data = d;
        if (to_b) in_valid_b = 1'b1;
        else      in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
    endtask

    // Expected level for every tick of the queued words, plus word end positions.
    task automatic build_model(input bit use_b);
        int h1, c1, h0, c0, h, c;
        bit lsb, v;
        h1 = use_b ? 2 : 1;
        c1 = use_b ? 2 : 1;
        h0 = 2;
        c0 = 1;
        lsb = !use_b;
        lv_q.delete();
        bnd_q.delete();
        foreach (wq[i]) begin
            for (int b = 0; b < 8; b++) begin
                v = lsb ? wq[i][b] : wq[i][7-b];
                h = v ? h1 : h0;
                c = v ? c1 : c0;
                for (int cy = 0; cy < c; cy++) begin
                    for (int j = 0; j < h; j++) lv_q.push_back(1'b1);
                    for (int j = 0; j < h; j++) lv_q.push_back(1'b0);
                end
            end
            bnd_q.push_back(lv_q.size());
        end
    endtask

    task automatic tx_check(input string tag, input bit use_b, input logic [23:0] step_v,
                            input int drop_at, input int stall_at, input int stall_len,
                            output int wd_first, output int wd_last);
        longint   cum;
        int       t, prev_t, len, extra;
        bit       exp_wd, is_bnd;
        logic [2:0] obs, expv;
        build_model(use_b);
        len      = lv_q.size();
        wd_first = -1;
        wd_last  = -1;
        cum      = 0;
        prev_t   = 0;
        extra    = 0;
        @(negedge clk);
        step   = step_v;
        enable = 1'b1;
        for (int k = 0; k < 20000 && extra < 2; k++) begin
            @(negedge clk);
            t = int'(cum >> 24);
            is_bnd = 1'b0;
            foreach (bnd_q[i]) if (bnd_q[i] == t) is_bnd = 1'b1;
            exp_wd = (t != prev_t) && is_bnd;
            expv = (t < len) ? {1'b1, lv_q[t], exp_wd} : {1'b0, 1'b1, exp_wd};
            obs  = use_b ? {busy_b, dout_b, word_done_b} : {busy, dout, word_done};
            check($sformatf("%s_cyc%0d{busy,dout,wd}", tag, k), {29'd0, obs}, {29'd0, expv});
            if (obs[0]) begin
                if (wd_first < 0) wd_first = k;
                wd_last = k;
            end
            if (t >= len) extra++;
            prev_t = t;
            if (k == drop_at) enable = 1'b0;
            if (k == stall_at) step = 24'd0;
            if (stall_at >= 0 && k == stall_at + stall_len) step = step_v;
            cum += longint'(step);
        end
        enable = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, n;
        bit ub;
        logic [23:0] sv;
        logic [7:0]  w;

        reset_n    = 1'b0;
        step       = 24'h800000;
        enable     = 1'b0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_word_done", word_done, 0);
        check("rst_dout", dout, 1);
        check("rst_dout_b", dout_b, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_dout", dout, 1);
        check("idle_busy", busy, 0);

        // Single word at tick-every-2-clk
        push(8'hA5, 0);
        check("a5_level", fifo_level, 1);
        wq = '{8'hA5};
        tx_check("a5", 0, 24'h800000, -1, -1, 0, f, l);
        check("a5_wd_cycle", f, 48);

        // Back-to-back words, no gap
        push(8'hFF, 0);
        push(8'h00, 0);
        wq = '{8'hFF, 8'h00};
        tx_check("b2b", 0, 24'h800000, -1, -1, 0, f, l);
        check("b2b_wd_first", f, 32);
        check("b2b_wd_last", l, 96);

        // FIFO full and overflow drop
        push(8'h11, 0);
        push(8'h22, 0);
        push(8'h33, 0);
        check("three_in_ready", in_ready, 1);
        push(8'h44, 0);
        check("full_in_ready", in_ready, 0);
        check("full_level", fifo_level, 4);
        push(8'hEE, 0);
        check("drop_level", fifo_level, 4);
        check("drop_in_ready", in_ready, 0);
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_check("full", 0, 24'h800000, -1, -1, 0, f, l);
        check("full_after_level", fifo_level, 0);
        check("full_after_ready", in_ready, 1);

        // Enable dropped during bit 3: word completes, then idle
        push(8'h0F, 0);
        push(8'h33, 0);
        wq = '{8'h0F};
        tx_check("endrop", 0, 24'h800000, 13, -1, 0, f, l);
        check("endrop_level", fifo_level, 1);
        check("endrop_busy", busy, 0);
        wq = '{8'h33};
        tx_check("enrest", 0, 24'h800000, -1, -1, 0, f, l);

        // Step held at zero mid-bit
        push(8'h5A, 0);
        wq = '{8'h5A};
        tx_check("stall", 0, 24'h600000, -1, 5, 23, f, l);

        // MSB-first instance with longer "1" tone
        push(8'h80, 1);
        wq = '{8'h80};
        tx_check("msb", 1, 24'h800000, -1, -1, 0, f, l);
        check("msb_wd_cycle", f, 72);

        // Random streams on both instances
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(4, 1);
            ub = (it % 2) == 1;
            sv = 24'($urandom_range(24'hFFFFFF, 24'h200000));
            wq.delete();
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom);
                wq.push_back(w);
                push(w, ub);
            end
            tx_check($sformatf("rnd%0d", it), ub, sv, -1, -1, 0, f, l);
        end

        // Async reset pulse between clock edges, mid-bit
        push(8'hC3, 0);
        push(8'h3C, 0);
        @(negedge clk);
        step   = 24'h800000;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("prerst_busy", busy, 1);
        check("prerst_dout", dout, 0);
        check("prerst_level", fifo_level, 1);
        #1 reset_n = 1'b0;
        #0.5;
        check("arst_dout", dout, 1);
        check("arst_busy", busy, 0);
        check("arst_level", fifo_level, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_word_done", word_done, 0);
        #0.5 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("postrst_busy%0d", i), busy, 0);
            check($sformatf("postrst_dout%0d", i), dout, 1);
        end
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cassette_fsk_encoder.md
Name: cassette_fsk_encoder

Overview:
- Parametrised FSK cassette-tape bit encoder for the MC-10 tape-out path.
- Buffers host bytes in a small FIFO and serialises each byte as square-wave tone bursts.
- Each bit is a configurable number of half-cycles of either a "1" tone or a "0" tone.
- Tone rate comes from a runtime phase-accumulator step, so normal and turbo save rates use the same block.

Parameters:
- ACC_W, 24, phase accumulator width; one tick per accumulator carry-out.
- DATA_W, 8, bits per serialised word.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
- HALF1, 1, ticks per half-cycle of a "1" bit tone (1..16).
- CYC1, 1, full tone cycles per "1" bit (1..16).
- HALF0, 2, ticks per half-cycle of a "0" bit tone (1..16).
- CYC0, 1, full tone cycles per "0" bit (1..16).
- LSB_FIRST, 1, 1 = shift out bit 0 first; 0 = MSB first.
- IDLE_LEVEL, 1, dout level while not transmitting.

Ports:
- clk, in, 1, system clock (4 MHz domain), all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- step, in, ACC_W, accumulator increment per clk; default system value 24'd20140.
- enable, in, 1, permits starting a new word.
- in_data, in, DATA_W, word to transmit.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, FIFO not full.
- dout, out, 1, square-wave tape output.
- busy, out, 1, high in BIT state.
- word_done, out, 1, one-clk pulse when the last bit of a word completes.
- fifo_level, out, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (async, reset_n low) clears:
  - FIFO pointers and count to 0; in_ready=1, fifo_level=0.
  - State to IDLE; busy=0, word_done=0, dout=IDLE_LEVEL.
  - Accumulator, counters and shift register to 0.
- Reset asserted mid-word aborts immediately; there is no partial completion.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = (count != FIFO_DEPTH), registered from count.
  - Push and pop in the same clk leave count unchanged.
  - in_valid while full is ignored; data is not stored and there is no error flag.
- States IDLE and BIT.
- IDLE -> BIT when enable & count != 0:
  - Pop head into shift register.
  - Clear accumulator, half-tick counter hcnt, cycle counter ccnt, phase and bit index.
  - busy=1 from the next clk.
- In BIT:
  - Each clk: {carry, acc} <= acc + step. tick = carry.
  - step=0 stalls the waveform indefinitely; this is legal.
  - cur = shift-register bit selected by LSB_FIRST. H = cur ? HALF1 : HALF0; C = cur ? CYC1 : CYC0.
  - dout = ~phase: high half-cycle first, then low.
  - On tick: if hcnt==H-1 then hcnt=0 and phase toggles; else hcnt++.
  - At the end of a low half (phase 1 -> 0): if ccnt==C-1 the bit ends; else ccnt++.
- Bit end:
  - ccnt=0; shift register advances; bit index++.
  - If index was DATA_W-1: word_done pulses in the same clk.
  - If also enable & FIFO non-empty: pop the next word with no gap; the accumulator is NOT cleared, so phase stays continuous.
  - Otherwise go to IDLE: dout=IDLE_LEVEL, busy=0.
- Deasserting enable mid-word does not abort; the current word finishes, then the block goes IDLE.
- Changing step mid-word takes effect on the next clk.
- Bit duration in ticks = 2*H*C.

Test Plan:
- Single word, defaults, step=24'h800000 (tick every 2 clk), push 8'hA5:
  - dout high 2 clk / low 2 clk for each "1"; high 4 / low 4 for each "0".
  - LSB first order: 1,0,1,0,0,1,0,1.
  - word_done exactly 48 clk after busy rises; then dout=1, busy=0.
- Back-to-back: push 8'hFF, 8'h00 with enable=1:
  - No idle gap between words; busy stays high.
  - word_done pulses twice, 32 and 96 clk after start.
- FIFO full: with enable=0, push 5 words into FIFO_DEPTH=4:
  - in_ready low after the 4th push; the 5th is dropped; fifo_level=4.
  - Raising enable transmits exactly the 4 words.
- Mid-word controls:
  - Drop enable during bit 3: the word completes, then IDLE despite FIFO non-empty.
  - Set step=0 mid-bit: dout freezes; restoring step resumes with correct remaining ticks.
- Async reset: pulse reset_n low for 1 ns mid-bit (no clk edge):
  - dout=1, busy=0, fifo_level=0 immediately.
- MSB mode: LSB_FIRST=0, HALF1=2, CYC1=2, push 8'h80:
  - First bit is the "1" tone of 8 ticks (two 2-high/2-low cycles); the remaining seven bits are "0" tones.
